// File: rtl/tjmono2_rx_merger_if.sv
// rtl/tjmono2_rx_merger_if.sv - lane-side and readout-side handshake bundle for the rx merger
interface tjmono2_rx_merger_if #(
    parameter int NCH        = 4,
    parameter int DATA_WIDTH = 24
);
    logic [NCH-1:0]            CH_EMPTY;
    logic [NCH*DATA_WIDTH-1:0] CH_DATA;
    logic [NCH-1:0]            CH_READ;
    logic                      FIFO_READ;
    logic                      FIFO_EMPTY;
    logic [31:0]               FIFO_DATA;
    logic                      FIFO_FULL;

    modport master (
        input  CH_EMPTY, CH_DATA, FIFO_READ,
        output CH_READ, FIFO_EMPTY, FIFO_DATA, FIFO_FULL
    );

    modport slave (
        output CH_EMPTY, CH_DATA, FIFO_READ,
        input  CH_READ, FIFO_EMPTY, FIFO_DATA, FIFO_FULL
    );
endinterface

// File: rtl/tjmono2_rx_merger.sv
// rtl/tjmono2_rx_merger.sv - round-robin N-lane merger into a tagged FWFT readout buffer
module tjmono2_rx_merger #(
    parameter int           NCH             = 4,
    parameter int           DATA_WIDTH      = 24,
    parameter int           DEPTH_LOG2      = 4,
    parameter logic [3:0]   DATA_IDENTIFIER = 4'd0
) (
    input  logic                  BUS_CLK,
    input  logic                  BUS_RST,
    tjmono2_rx_merger_if.master   bus,
    input  logic [NCH-1:0]        CONF_EN_MASK,
    input  logic [7:0]            CONF_MAX_BURST,
    input  logic                  CONF_CNT_CLR,
    output logic                  BUSY,
    output logic [NCH*16-1:0]     CH_WORD_CNT
);
    localparam int CW    = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic {IDLE, GRANT} state_t;

    state_t                state;
    logic [CW-1:0]         ptr;
    logic [CW-1:0]         cur;
    logic [CW-1:0]         nxt_ch;
    logic                  found;
    logic [7:0]            burst_cnt;
    logic                  src_ok;
    logic                  burst_ok;
    logic                  rd_en;
    logic                  hold;
    logic                  rd_buf;
    logic                  buf_empty;
    logic                  buf_full;
    logic [DEPTH_LOG2:0]   count;
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [31:0]           mem [DEPTH];
    logic [DATA_WIDTH-1:0] payload;
    logic [31:0]           wr_word;
    logic [15:0]           cnt [NCH];

    // Rotating search starting just after the last served channel.
    always_comb begin
        found  = 1'b0;
        nxt_ch = '0;
        for (int k = 1; k <= NCH; k++) begin
            if (!found && CONF_EN_MASK[(int'(ptr) + k) % NCH] && !bus.CH_EMPTY[(int'(ptr) + k) % NCH]) begin
                found  = 1'b1;
                nxt_ch = CW'((int'(ptr) + k) % NCH);
            end
        end
    end

    assign buf_empty = (count == '0);
    assign buf_full  = (count == (DEPTH_LOG2+1)'(DEPTH));
    assign src_ok    = !bus.CH_EMPTY[cur] && CONF_EN_MASK[cur];
    assign burst_ok  = (CONF_MAX_BURST == 8'd0) || (burst_cnt < CONF_MAX_BURST);
    assign rd_en     = (state == GRANT) && src_ok && burst_ok && !buf_full;
    // A full buffer alone keeps the grant; any other stop condition releases it.
    assign hold      = (state == GRANT) && src_ok && burst_ok && buf_full;
    assign rd_buf    = bus.FIFO_READ && !buf_empty;

    always_comb begin
        bus.CH_READ = '0;
        if (rd_en) bus.CH_READ[cur] = 1'b1;
    end

    always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
        if (BUS_RST) begin
            state     <= IDLE;
            ptr       <= CW'(NCH - 1);
            cur       <= '0;
            burst_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        cur       <= nxt_ch;
                        burst_cnt <= '0;
                        state     <= GRANT;
                    end
                end
                GRANT: begin
                    if (rd_en) begin
                        if (burst_cnt != 8'hFF) burst_cnt <= burst_cnt + 8'd1;
                    end else if (!hold) begin
                        ptr   <= cur;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign BUSY    = (state == GRANT);
    assign payload = bus.CH_DATA[int'(cur)*DATA_WIDTH +: DATA_WIDTH];
    assign wr_word = {DATA_IDENTIFIER, 4'(cur), 24'(payload)};

    always_ff @(posedge BUS_CLK) begin
        if (rd_en) mem[wr_ptr] <= wr_word;
    end

    always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
        if (BUS_RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (rd_en)  wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
            if (rd_buf) rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
            case ({rd_en, rd_buf})
                2'b10:   count <= count + (DEPTH_LOG2+1)'(1);
                2'b01:   count <= count - (DEPTH_LOG2+1)'(1);
                default: count <= count;
            endcase
        end
    end

    assign bus.FIFO_EMPTY = buf_empty;
    assign bus.FIFO_FULL  = buf_full;
    assign bus.FIFO_DATA  = buf_empty ? 32'd0 : mem[rd_ptr];

    always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
        if (BUS_RST) begin
            for (int i = 0; i < NCH; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (CONF_CNT_CLR)                              cnt[i] <= '0;
                else if (bus.CH_READ[i] && cnt[i] != 16'hFFFF) cnt[i] <= cnt[i] + 16'd1;
            end
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_cnt
        assign CH_WORD_CNT[g*16 +: 16] = cnt[g];
    end
endmodule

// File: tb/tb_tjmono2_rx_merger.sv
// tb/tb_tjmono2_rx_merger.sv - scoreboard bench for tjmono2_rx_merger
module tb_tjmono2_rx_merger;
    localparam int         NCH = 4;
    localparam int         DW  = 24;
    localparam int         DL2 = 2;
    localparam logic [3:0] DID = 4'hA;

    logic              BUS_CLK = 1'b0;
    logic              BUS_RST;
    logic [NCH-1:0]    CONF_EN_MASK;
    logic [7:0]        CONF_MAX_BURST;
    logic              CONF_CNT_CLR;
    logic              BUSY;
    logic [NCH*16-1:0] CH_WORD_CNT;

    tjmono2_rx_merger_if #(.NCH(NCH), .DATA_WIDTH(DW)) bus ();

    tjmono2_rx_merger #(.NCH(NCH), .DATA_WIDTH(DW), .DEPTH_LOG2(DL2), .DATA_IDENTIFIER(DID)) dut (
        .BUS_CLK        (BUS_CLK),
        .BUS_RST        (BUS_RST),
        .bus            (bus),
        .CONF_EN_MASK   (CONF_EN_MASK),
        .CONF_MAX_BURST (CONF_MAX_BURST),
        .CONF_CNT_CLR   (CONF_CNT_CLR),
        .BUSY           (BUSY),
        .CH_WORD_CNT    (CH_WORD_CNT)
    );

    always #5 BUS_CLK = ~BUS_CLK;

    int          checks = 0;
    int          passed = 0;
    logic [23:0] src_q [NCH][$];
    logic [31:0] exp_q [$];
    int          exp_cnt [NCH];
    int          pops [NCH];
    int          rd_pct = 0;
    int          m_start = 0;
    logic [NCH-1:0] rd_smp;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act === expv) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, expv);
    endtask

    task automatic refresh();
        for (int i = 0; i < NCH; i++) begin
            bus.CH_EMPTY[i]          = (src_q[i].size() == 0);
            bus.CH_DATA[i*DW +: DW]  = (src_q[i].size() == 0) ? 24'd0 : src_q[i][0];
        end
    endtask

    function automatic int pending(input logic [NCH-1:0] m);
        int p = exp_q.size();
        for (int i = 0; i < NCH; i++) if (m[i]) p += src_q[i].size();
        return p;
    endfunction

    // Reference ordering: visit channels round-robin, each grant takes up to burst words.
    task automatic schedule(input logic [NCH-1:0] mask, input int burst);
        int rem [NCH];
        int taken [NCH];
        for (int i = 0; i < NCH; i++) begin rem[i] = src_q[i].size(); taken[i] = 0; end
        while (1) begin
            int ch = -1;
            int n;
            for (int k = 0; k < NCH; k++) begin
                int c = (m_start + k) % NCH;
                if (ch < 0 && mask[c] && rem[c] > 0) ch = c;
            end
            if (ch < 0) break;
            n = (burst == 0 || rem[ch] < burst) ? rem[ch] : burst;
            for (int j = 0; j < n; j++) exp_q.push_back({DID, 4'(ch), src_q[ch][taken[ch] + j]});
            taken[ch] += n;
            rem[ch]   -= n;
            m_start    = (ch + 1) % NCH;
        end
    endtask

    task automatic wait_drain(input string name, input int limit, input logic [NCH-1:0] m);
        int n = 0;
        while (pending(m) != 0 && n < limit) begin @(posedge BUS_CLK); n++; end
        chk({name, "_drain"}, 32'(n < limit), 32'd1);
        repeat (3) @(posedge BUS_CLK);
    endtask

    task automatic chk_counters(input string name);
        for (int i = 0; i < NCH; i++) chk(name, 32'(CH_WORD_CNT[i*16 +: 16]), 32'(exp_cnt[i]));
    endtask

    // Lane model: pops the head of a channel queue on every sampled CH_READ.
    initial begin
        forever begin
            @(negedge BUS_CLK);
            rd_smp = bus.CH_READ;
            @(posedge BUS_CLK);
            #1;
            for (int i = 0; i < NCH; i++) begin
                if (rd_smp[i] && !BUS_RST) begin
                    if (src_q[i].size() == 0) chk("read_of_empty_lane", 32'd1, 32'd0);
                    else begin void'(src_q[i].pop_front()); pops[i]++; end
                end
            end
            refresh();
        end
    end

    // Monitor: pops the readout buffer at a random rate and checks each word.
    initial begin
        logic [31:0] w;
        bus.FIFO_READ = 1'b0;
        forever begin
            @(negedge BUS_CLK);
            bus.FIFO_READ = 1'b0;
            if (!BUS_RST && !bus.FIFO_EMPTY && ($urandom_range(99) < rd_pct)) begin
                bus.FIFO_READ = 1'b1;
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_word: got %h expected none", bus.FIFO_DATA);
                end else begin
                    w = exp_q.pop_front();
                    chk("fifo_data", bus.FIFO_DATA, w);
                    if (exp_cnt[w[27:24]] < 16'hFFFF) exp_cnt[w[27:24]]++;
                end
            end
        end
    end

    initial begin
        logic [23:0] wa;
        int n;
        int pc;
        logic [NCH-1:0] msk;
        int burst;

        BUS_RST        = 1'b1;
        CONF_EN_MASK   = '1;
        CONF_MAX_BURST = 8'd0;
        CONF_CNT_CLR   = 1'b0;
        refresh();
        repeat (3) @(negedge BUS_CLK);
        chk("rst_empty", 32'(bus.FIFO_EMPTY), 32'd1);
        chk("rst_full",  32'(bus.FIFO_FULL), 32'd0);
        chk("rst_data",  bus.FIFO_DATA, 32'd0);
        chk("rst_read",  32'(bus.CH_READ), 32'd0);
        chk("rst_busy",  32'(BUSY), 32'd0);
        chk("rst_cnt",   CH_WORD_CNT[31:0], 32'd0);
        BUS_RST = 1'b0;

        // Single channel, latency and grant timing.
        @(posedge BUS_CLK); #2;
        wa = 24'($urandom);
        src_q[2].push_back(wa);
        src_q[2].push_back(24'($urandom));
        src_q[2].push_back(24'($urandom));
        schedule('1, 0);
        refresh();
        @(negedge BUS_CLK);
        chk("t1_idle_busy", 32'(BUSY), 32'd0);
        chk("t1_idle_read", 32'(bus.CH_READ), 32'd0);
        @(negedge BUS_CLK);
        chk("t1_grant_busy", 32'(BUSY), 32'd1);
        chk("t1_read1", 32'(bus.CH_READ), 32'b0100);
        chk("t1_still_empty", 32'(bus.FIFO_EMPTY), 32'd1);
        @(negedge BUS_CLK);
        chk("t1_visible", 32'(bus.FIFO_EMPTY), 32'd0);
        chk("t1_first_word", bus.FIFO_DATA, {DID, 4'd2, wa});
        chk("t1_read2", 32'(bus.CH_READ), 32'b0100);
        @(negedge BUS_CLK);
        chk("t1_read3", 32'(bus.CH_READ), 32'b0100);
        @(negedge BUS_CLK);
        chk("t1_read_stop", 32'(bus.CH_READ), 32'd0);
        chk("t1_pops", 32'(pops[2]), 32'd3);
        rd_pct = 100;
        wait_drain("t1", 200, '1);
        chk_counters("t1_cnt");

        // All channels, burst limit 2.
        @(posedge BUS_CLK); #2;
        CONF_MAX_BURST = 8'd2;
        rd_pct = 60;
        for (int i = 0; i < NCH; i++) for (int j = 0; j < 5; j++) src_q[i].push_back(24'($urandom));
        schedule('1, 2);
        refresh();
        wait_drain("t2", 1000, '1);
        chk_counters("t2_cnt");

        // Backpressure: full buffer keeps the grant.
        @(posedge BUS_CLK); #2;
        CONF_MAX_BURST = 8'd0;
        rd_pct = 0;
        for (int j = 0; j < 10; j++) src_q[0].push_back(24'($urandom));
        schedule('1, 0);
        refresh();
        repeat (20) @(negedge BUS_CLK);
        chk("t3_pops", 32'(pops[0] - exp_cnt[0]), 32'd4);
        chk("t3_full", 32'(bus.FIFO_FULL), 32'd1);
        chk("t3_read", 32'(bus.CH_READ), 32'd0);
        chk("t3_busy", 32'(BUSY), 32'd1);
        rd_pct = 100;
        wait_drain("t3", 500, '1);
        chk_counters("t3_cnt");

        // Disable ch1 mid-burst.
        @(posedge BUS_CLK); #2;
        rd_pct = 100;
        pc = pops[1];
        for (int j = 0; j < 6; j++) src_q[1].push_back(24'($urandom));
        for (int j = 0; j < 2; j++) src_q[2].push_back(24'($urandom));
        exp_q.push_back({DID, 4'd1, src_q[1][0]});
        exp_q.push_back({DID, 4'd1, src_q[1][1]});
        exp_q.push_back({DID, 4'd2, src_q[2][0]});
        exp_q.push_back({DID, 4'd2, src_q[2][1]});
        refresh();
        n = 0;
        while (pops[1] - pc < 2 && n < 200) begin @(posedge BUS_CLK); #2; n++; end
        chk("t4_wait", 32'(n < 200), 32'd1);
        CONF_EN_MASK[1] = 1'b0;
        wait_drain("t4a", 500, 4'b1101);
        chk("t4_no_more_reads", 32'(pops[1] - pc), 32'd2);
        chk("t4_left", 32'(src_q[1].size()), 32'd4);
        @(posedge BUS_CLK); #2;
        for (int j = 0; j < 4; j++) exp_q.push_back({DID, 4'd1, src_q[1][j]});
        CONF_EN_MASK = '1;
        m_start = 2;
        wait_drain("t4b", 500, '1);
        chk_counters("t4_cnt");

        // Randomised rounds.
        for (int r = 0; r < 6; r++) begin
            @(posedge BUS_CLK); #2;
            msk   = 4'($urandom_range(1, 15));
            burst = $urandom_range(0, 3);
            rd_pct = $urandom_range(30, 100);
            CONF_EN_MASK   = msk;
            CONF_MAX_BURST = 8'(burst);
            for (int i = 0; i < NCH; i++)
                if (msk[i]) begin
                    n = $urandom_range(0, 6);
                    for (int j = 0; j < n; j++) src_q[i].push_back(24'($urandom));
                end
            schedule(msk, burst);
            refresh();
            wait_drain("rand", 2000, '1);
        end
        chk_counters("rand_cnt");

        // Asynchronous reset with words buffered.
        @(posedge BUS_CLK); #2;
        CONF_EN_MASK   = '1;
        CONF_MAX_BURST = 8'd0;
        rd_pct = 0;
        pc = pops[0];
        for (int j = 0; j < 8; j++) src_q[0].push_back(24'($urandom));
        refresh();
        n = 0;
        while (pops[0] - pc < 3 && n < 200) begin @(posedge BUS_CLK); #2; n++; end
        chk("t6_wait", 32'(n < 200), 32'd1);
        chk("t6_buffered", 32'(bus.FIFO_EMPTY), 32'd0);
        #1 BUS_RST = 1'b1;
        #1;
        chk("t6_empty", 32'(bus.FIFO_EMPTY), 32'd1);
        chk("t6_data",  bus.FIFO_DATA, 32'd0);
        chk("t6_read",  32'(bus.CH_READ), 32'd0);
        chk("t6_busy",  32'(BUSY), 32'd0);
        chk("t6_cnt_lo", CH_WORD_CNT[31:0], 32'd0);
        chk("t6_cnt_hi", CH_WORD_CNT[63:32], 32'd0);
        exp_q.delete();
        for (int i = 0; i < NCH; i++) exp_cnt[i] = 0;
        for (int j = 0; j < 2; j++) src_q[3].push_back(24'($urandom));
        refresh();
        m_start = 0;
        schedule('1, 0);
        @(negedge BUS_CLK);
        BUS_RST = 1'b0;
        rd_pct = 100;
        wait_drain("t6", 500, '1);
        chk_counters("t6_cnt");

        // Saturation and clear priority on ch3.
        @(posedge BUS_CLK); #2;
        rd_pct = 100;
        pc = pops[3];
        for (int j = 0; j < 65545; j++) src_q[3].push_back(24'(j));
        schedule('1, 0);
        refresh();
        n = 0;
        while (pops[3] - pc < 65540 && n < 70000) begin @(posedge BUS_CLK); #2; n++; end
        chk("t7_wait", 32'(n < 70000), 32'd1);
        chk("t7_saturated", 32'(CH_WORD_CNT[48 +: 16]), 32'h0000FFFF);
        @(negedge BUS_CLK);
        chk("t7_read_at_clr", 32'(bus.CH_READ), 32'b1000);
        CONF_CNT_CLR = 1'b1;
        @(posedge BUS_CLK); #2;
        CONF_CNT_CLR = 1'b0;
        n = pops[3] - pc;
        chk("t7_cleared", 32'(CH_WORD_CNT[48 +: 16]), 32'd0);
        wait_drain("t7", 200, '1);
        chk("t7_after_clr", 32'(CH_WORD_CNT[48 +: 16]), 32'(65545 - n));
        chk("t7_other_cleared", 32'(CH_WORD_CNT[0 +: 16]), 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/tjmono2_rx_merger.md
Name: tjmono2_rx_merger

Overview:
- Parametrised N-channel readout merger. Sits between the per-lane receiver FIFOs (first-word-fall-through, BUS_CLK side) and the single 32-bit readout FIFO port.
- Round-robin arbitration with a configurable burst limit and per-channel enable.
- Tags each word with a data identifier and a channel ID, and buffers the result in an internal FWFT FIFO.
- Keeps saturating per-channel word counters for monitoring.

Parameters:
- NCH, 4, number of input channels; legal range 1..16.
- DATA_WIDTH, 24, payload bits per channel word; legal range 1..24; zero-padded into bits [23:0].
- DEPTH_LOG2, 4, output buffer depth = 2^DEPTH_LOG2 words.
- DATA_IDENTIFIER, 0, 4-bit tag placed in FIFO_DATA[31:28].

Ports:
- BUS_CLK  in  1  single clock for all logic.
- BUS_RST  in  1  asynchronous, active-high reset.
- CH_EMPTY  in  NCH  per-channel FWFT empty flag.
- CH_DATA  in  NCH*DATA_WIDTH  per-channel head word; channel i occupies [i*DATA_WIDTH +: DATA_WIDTH].
- CH_READ  out  NCH  per-channel pop strobe.
- CONF_EN_MASK  in  NCH  channel enable; 0 = channel is never served.
- CONF_MAX_BURST  in  8  maximum consecutive words per grant; 0 = unlimited.
- CONF_CNT_CLR  in  1  synchronous clear of all word counters.
- FIFO_READ  in  1  pop from the output buffer.
- FIFO_EMPTY  out  1  output buffer empty.
- FIFO_DATA  out  32  {DATA_IDENTIFIER[3:0], ch_id[3:0], zero-pad, payload}.
- FIFO_FULL  out  1  output buffer holds 2^DEPTH_LOG2 words.
- BUSY  out  1  arbiter is in GRANT.
- CH_WORD_CNT  out  NCH*16  per-channel saturating count of words transferred.

Behaviour:
- Reset (asynchronous, BUS_RST=1):
  - State IDLE, ptr=NCH-1, burst_cnt=0.
  - Buffer empty: FIFO_EMPTY=1, FIFO_FULL=0, FIFO_DATA=0.
  - CH_READ=0, BUSY=0, all counters 0.
  - Buffered words are discarded; reset mid-burst drops nothing from the channel side beyond words already popped.
- Arbiter states:
  - IDLE: search channels in order ptr+1 … ptr+NCH (mod NCH). The first one with CONF_EN_MASK=1 and CH_EMPTY=0 is granted: cur<=ch, burst_cnt<=0, next state GRANT. No read is issued in IDLE.
  - GRANT: CH_READ[cur] = !CH_EMPTY[cur] & CONF_EN_MASK[cur] & !FIFO_FULL & (CONF_MAX_BURST==0 | burst_cnt<CONF_MAX_BURST). This is combinational from registered state plus inputs; all other CH_READ bits are 0.
  - Each read increments burst_cnt.
  - When the read condition is false, the arbiter leaves GRANT: ptr<=cur, next state IDLE. There is exactly one re-arbitration bubble.
  - Exception: if the read condition is false only because FIFO_FULL=1, the arbiter stays in GRANT (backpressure does not cost the grant).
  - Disabling the current channel mid-burst: no read that cycle, exit to IDLE.
- Data path:
  - A word popped at cycle t is written into the buffer at the edge ending cycle t.
  - It is visible on FIFO_DATA with FIFO_EMPTY=0 from cycle t+1 if the buffer was empty (1-cycle latency).
- Buffer:
  - FWFT; FIFO_DATA is the head word whenever FIFO_EMPTY=0.
  - FIFO_READ while empty is ignored.
  - Simultaneous write and read when not full: occupancy unchanged.
  - When full, no write occurs even if FIFO_READ=1 in the same cycle (guaranteed by the CH_READ gating).
  - Pointers wrap modulo 2^DEPTH_LOG2.
- Counters:
  - CH_WORD_CNT[i] increments on each CH_READ[i] and saturates at 16'hFFFF.
  - CONF_CNT_CLR has priority over an increment in the same cycle.
- Channel ID: ch_id = cur, zero-extended to 4 bits. With NCH=1 the ID is always 0.
- Ordering: words from one channel leave in arrival order; interleaving between channels follows the grant order.

Test Plan:
- NCH=4, MAX_BURST=0, only ch2 holds 3 words A,B,C -> IDLE→GRANT in 1 cycle; CH_READ[2] high 3 cycles; FIFO_DATA[27:24]=2; words A,B,C in order; CH_WORD_CNT[2]=3; first word visible 1 cycle after first pop.
- All 4 channels hold 5 words, MAX_BURST=2 -> grant order 0,0,1,1,2,2,3,3,0,0,…; one bubble between grants; all 20 words delivered; each counter=5.
- DEPTH_LOG2=2, FIFO_READ=0, ch0 holds 10 words -> exactly 4 pops; FIFO_FULL=1; CH_READ=0; BUSY stays 1. Start FIFO_READ=1 continuously -> remaining 6 words delivered with no loss or duplication.
- CONF_EN_MASK[1] cleared mid-burst on ch1 -> no further CH_READ[1]; arbiter moves to the next enabled channel; ch1 words are untouched until re-enabled.
- Force 65540 pops on ch3 -> CH_WORD_CNT[3]=16'hFFFF. CONF_CNT_CLR asserted together with a pop -> counter=0.
- BUS_RST asserted asynchronously mid-burst with 3 words buffered -> FIFO_EMPTY=1, CH_READ=0, counters=0 immediately without a clock edge. After release, arbitration restarts at ch0.
